// File: rtl/nn_pkg.sv
// Shared constants and state type for the NN input-side pixel streamer.
package nn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } streamer_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO between the image buffer read port and the pixel
// consumer. DEPTH must be a power of two so the pointers wrap for free.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module pixel_fifo import nn_pkg::*; #(
    parameter int  DEPTH = FIFO_DEPTH,
    parameter int  WIDTH = PIX_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             pushEn;
    logic             popEn;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign popEn   = pop_i && !empty_o;
    assign pushEn  = push_i && (!full_o || popEn);
    assign count_o = count_q;
    // Head is forced to zero while empty so the output never shows stale storage.
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (pushEn && !popEn) begin
                count_q <= count_q + CW'(1);
            end else if (popEn && !pushEn) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pixel_streamer.sv
// Streams one stored image frame out of the image buffer, pixel by pixel in
// address order, to the first NN layer over a valid/ready handshake.
// Reads are issued on a credit basis so the output FIFO can never overflow:
// a read is only scheduled when queued pixels plus the read still in flight
// leave room for it. The buffer always answers exactly one cycle after a read.
module pixel_streamer import nn_pkg::*; #(
    parameter int NUM_PIXELS = nn_pkg::NUM_PIXELS,
    parameter int ADDR_W     = nn_pkg::ADDR_W,
    parameter int FIFO_DEPTH = nn_pkg::FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    image_written,
    output logic                    read_request,
    output logic [ADDR_W-1:0]       addr,
    input  logic signed [PIX_W-1:0] data_in,
    input  logic                    valid_data,
    output logic signed [PIX_W-1:0] pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_last,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = FCW + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_PIXELS);

    streamer_state_e   state_q, state_d;
    logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;
    logic [CNT_W-1:0]  outCnt_q, outCnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              readRequest_q, readRequest_d;
    logic              expect_q, expect_d;
    logic              frameDone_q, frameDone_d;
    logic              busy_q, busy_d;
    logic              imagePrev_q;

    logic [PIX_W-1:0]  fifoData;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [FCW-1:0]    fifoCount;

    logic              pushReq;
    logic              pushAcc;
    logic              popEn;
    logic              lastAccept;
    logic              imageRise;
    logic [OCC_W-1:0]  occNext;

    // Only data answering a read from the previous cycle is queued; anything else is noise.
    assign pushReq    = valid_data && expect_q;
    assign popEn      = pix_valid && pix_ready;
    assign pushAcc    = pushReq && (!fifoFull || popEn);
    assign pix_valid  = !fifoEmpty;
    assign pix_data   = fifoData;
    assign pix_last   = pix_valid && (outCnt_q == LAST_IDX);
    assign lastAccept = popEn && pix_last;
    assign imageRise  = image_written && !imagePrev_q;

    // Occupancy the FIFO will hold next cycle plus the read issued this cycle,
    // which will still be in flight when the next read would go out.
    assign occNext = OCC_W'(fifoCount) + OCC_W'(pushAcc) + OCC_W'(readRequest_q) - OCC_W'(popEn);

    assign read_request = readRequest_q;
    assign addr         = addr_q;
    assign frame_done   = frameDone_q;
    assign busy         = busy_q;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pushAcc),
        .data_i  (data_in),
        .pop_i   (popEn),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Next-state and next-output logic; outputs are precomputed so they leave the block registered.
    always_comb begin
        state_d       = state_q;
        rdCnt_d       = rdCnt_q;
        outCnt_d      = outCnt_q;
        addr_d        = addr_q;
        readRequest_d = 1'b0;
        expect_d      = readRequest_q;

        case (state_q)
            ST_IDLE: begin
                if (imageRise) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rdCnt_q == FRAME_LEN) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (lastAccept) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rdCnt_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_FETCH) && (rdCnt_q != FRAME_LEN) &&
            (occNext < OCC_W'(FIFO_DEPTH))) begin
            readRequest_d = 1'b1;
            addr_d        = ADDR_W'(rdCnt_q);
            rdCnt_d       = rdCnt_q + CNT_W'(1);
        end

        if (popEn) begin
            outCnt_d = lastAccept ? '0 : outCnt_q + CNT_W'(1);
        end

        frameDone_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Streamer FSM and registered outputs. The trigger history keeps tracking the
    // input through reset so a level held high across reset cannot fake an edge.
    always_ff @(posedge clk) begin
        imagePrev_q <= image_written;
        if (reset) begin
            state_q       <= ST_IDLE;
            rdCnt_q       <= '0;
            outCnt_q      <= '0;
            addr_q        <= '0;
            readRequest_q <= 1'b0;
            expect_q      <= 1'b0;
            frameDone_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdCnt_q       <= rdCnt_d;
            outCnt_q      <= outCnt_d;
            addr_q        <= addr_d;
            readRequest_q <= readRequest_d;
            expect_q      <= expect_d;
            frameDone_q   <= frameDone_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: a one-cycle-latency image buffer model filled with
// random pixels, a table of ready patterns, and hand-written reset/retrigger
// and spurious-data sequences. Expected pixels come from the frame contents in
// address order; handshake expectations come from the cycle rules of the block.
module tb_pixel_streamer;

    localparam int NUM   = 784;
    localparam int DEPTH = 4;
    localparam int BOUND = 4000;

    localparam int M_ALWAYS = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_STALL  = 2;
    localparam int M_RANDOM = 3;

    typedef struct {
        string name;
        int    mode;
        int    stallLen;
        int    expDone;
        int    expStallReads;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        image_written;
    logic        read_request;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        valid_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        frame_done;
    logic        busy;

    int          checks;
    int          errors;
    int          lastAddrModel;
    logic [7:0]  patMem [NUM];
    bit          injectSpurious;

    pixel_streamer #(
        .NUM_PIXELS (NUM),
        .ADDR_W     (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .image_written (image_written),
        .read_request  (read_request),
        .addr          (addr),
        .data_in       (data_in),
        .valid_data    (valid_data),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_last      (pix_last),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Image buffer model: a read seen in one cycle is answered in the next.
    initial begin
        bit          pendReq;
        logic [15:0] pendAddr;
        pendReq    = 1'b0;
        pendAddr   = '0;
        valid_data = 1'b0;
        data_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            valid_data = pendReq | injectSpurious;
            if (pendReq && (int'(pendAddr) < NUM)) begin
                data_in = patMem[pendAddr];
            end else begin
                data_in = 8'h55;
            end
            pendReq  = read_request;
            pendAddr = addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_read_request", read_request, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_pix_data", pix_data, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pix_last", pix_last, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    // Runs one frame from a fresh trigger edge, checking every cycle against
    // the frame contents and the handshake rules. abortAt >= 0 stops the run
    // once that many pixels have been accepted, leaving the frame mid-flight.
    task automatic applyStimulus(input int mode, input int stallLen, input int abortAt,
                                 output int doneStep, output int stallReads,
                                 output int pixCount, output int firstValid);
        int         issued;
        int         accepted;
        bit         doneExpected;
        bit         prevStall;
        bit         finished;
        bit         rdy;
        logic [7:0] prevData;

        issued       = 0;
        accepted     = 0;
        doneExpected = 1'b0;
        prevStall    = 1'b0;
        finished     = 1'b0;
        prevData     = '0;
        doneStep     = -1;
        stallReads   = 0;
        firstValid   = -1;

        for (int a = 0; a < NUM; a++) begin
            patMem[a] = 8'($urandom);
        end

        pix_ready     = 1'b0;
        image_written = 1'b0;
        step();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_read_request", read_request, 0);
        checkOutput("idle_addr_hold", addr, lastAddrModel);
        image_written = 1'b1;

        for (int k = 1; k <= BOUND && !finished; k++) begin
            step();
            checkOutput("busy_in_frame", busy, 1);
            checkOutput("frame_done", frame_done, doneExpected);
            doneExpected = 1'b0;

            if (read_request) begin
                checkOutput("addr_seq", addr, issued);
                issued++;
                lastAddrModel = issued - 1;
                checkOutput("read_count_in_range", (issued <= NUM) ? 1 : 0, 1);
                checkOutput("read_credit", (issued - accepted <= DEPTH) ? 1 : 0, 1);
                if (k <= stallLen) begin
                    stallReads++;
                end
            end else begin
                checkOutput("addr_hold", addr, lastAddrModel);
            end

            if (prevStall) begin
                checkOutput("stall_valid", pix_valid, 1);
                checkOutput("stall_data", pix_data, prevData);
            end

            case (mode)
                M_TOGGLE: rdy = k[0];
                M_STALL:  rdy = (k > stallLen);
                M_RANDOM: rdy = ($urandom_range(0, 3) != 0);
                default:  rdy = 1'b1;
            endcase
            pix_ready = rdy;

            if (pix_valid && (firstValid < 0)) begin
                firstValid = k;
            end

            if (frame_done) begin
                doneStep = k;
                finished = 1'b1;
                checkOutput("done_no_valid", pix_valid, 0);
            end else if (pix_valid && pix_ready) begin
                checkOutput("pix_data", pix_data, patMem[accepted]);
                checkOutput("pix_last", pix_last, (accepted == NUM - 1) ? 1 : 0);
                accepted++;
                if (accepted == NUM) begin
                    doneExpected = 1'b1;
                end
                if ((abortAt >= 0) && (accepted == abortAt)) begin
                    finished = 1'b1;
                end
            end

            prevStall = pix_valid && !pix_ready;
            prevData  = pix_data;
        end

        checkOutput("frame_terminated", finished, 1);
        pixCount = accepted;

        if (abortAt < 0) begin
            step();
            checkOutput("done_single_pulse", frame_done, 0);
            checkOutput("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   doneStep;
        int   stallReads;
        int   pixCount;
        int   firstValid;

        vecs[0] = '{name: "stream", mode: M_ALWAYS, stallLen: 0,  expDone: 787, expStallReads: -1};
        vecs[1] = '{name: "toggle", mode: M_TOGGLE, stallLen: 0,  expDone: 0,   expStallReads: -1};
        vecs[2] = '{name: "stall",  mode: M_STALL,  stallLen: 50, expDone: 835, expStallReads: DEPTH};
        vecs[3] = '{name: "random", mode: M_RANDOM, stallLen: 0,  expDone: 0,   expStallReads: -1};

        checks         = 0;
        errors         = 0;
        lastAddrModel  = 0;
        injectSpurious = 1'b0;
        reset          = 1'b1;
        image_written  = 1'b0;
        pix_ready      = 1'b0;

        step();
        step();
        checkResetValues();
        reset = 1'b0;
        step();

        // Stray valid_data while idle must not enter the FIFO.
        $display("[TB] spurious valid_data while idle");
        injectSpurious = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("spurious_idle_valid", pix_valid, 0);
        end
        injectSpurious = 1'b0;
        step();
        step();
        checkOutput("spurious_idle_valid_after", pix_valid, 0);

        for (int v = 0; v < 4; v++) begin
            $display("[TB] frame pattern %s", vecs[v].name);
            if (vecs[v].mode == M_STALL) begin
                fork
                    begin
                        repeat (22) step();
                        injectSpurious = 1'b1;
                        step();
                        injectSpurious = 1'b0;
                    end
                join_none
            end
            applyStimulus(vecs[v].mode, vecs[v].stallLen, -1, doneStep, stallReads, pixCount, firstValid);
            checkOutput({vecs[v].name, "_pixel_count"}, pixCount, NUM);
            checkOutput({vecs[v].name, "_first_valid"}, firstValid, 3);
            if (vecs[v].expDone > 0) begin
                checkOutput({vecs[v].name, "_done_cycle"}, doneStep, vecs[v].expDone);
            end
            if (vecs[v].expStallReads >= 0) begin
                checkOutput({vecs[v].name, "_stall_reads"}, stallReads, vecs[v].expStallReads);
            end

            // Trigger level still high after the frame: nothing may restart.
            for (int i = 0; i < 10; i++) begin
                step();
                checkOutput("hold_high_busy", busy, 0);
                checkOutput("hold_high_read", read_request, 0);
            end
        end

        // Reset in the middle of a frame, then a clean restart from address 0.
        $display("[TB] reset mid-frame at pixel 300");
        applyStimulus(M_ALWAYS, 0, 300, doneStep, stallReads, pixCount, firstValid);
        checkOutput("abort_pixel_count", pixCount, 300);
        reset = 1'b1;
        step();
        checkResetValues();
        lastAddrModel = 0;
        reset         = 1'b0;
        image_written = 1'b0;
        pix_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_reset_valid", pix_valid, 0);
            checkOutput("post_reset_busy", busy, 0);
        end
        applyStimulus(M_ALWAYS, 0, -1, doneStep, stallReads, pixCount, firstValid);
        checkOutput("restart_pixel_count", pixCount, NUM);
        checkOutput("restart_done_cycle", doneStep, 787);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
